regfile_scoreboard: RTL and testbench

Parametrised MIPS register file with two asynchronous read ports, two synchronous write ports, same-cycle write-through bypass and a per-register busy scoreboard. It replaces the single-write-port register file in the pipelined core. Write port 3 serves ALU write-back and write port 4 serves load write-back. Decode reserves destination registers through the scoreboard so hazard logic can stall on registers whose results are still in flight.

---
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with two combinational read ports, two write ports and a
//   per-register busy scoreboard. The same-cycle bypass gives consumers the
//   data being written this cycle. Port 4 (load write-back) has priority over
//   port 3 (ALU write-back). Decode marks a destination busy through rsv_*.
//
//   Ports
//     clk            rising-edge clock
//     reset          synchronous, active-high
//     ra1/ra2        read addresses
//     rd1/rd2        read data with bypass (combinational)
//     busy1/busy2    scoreboard status of ra1/ra2 (combinational)
//     we3/wa3/wd3    write port 3 (ALU write-back)
//     we4/wa4/wd4    write port 4 (load write-back)
//     rsv_en/rsv_addr  reserve (mark busy) a destination register
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy1,
   output logic              busy2,
   input  logic              we3,
   input  logic [ADDR_W-1:0] wa3,
   input  logic [DATA_W-1:0] wd3,
   input  logic              we4,
   input  logic [ADDR_W-1:0] wa4,
   input  logic [DATA_W-1:0] wd4,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_next;
   logic [NREG-1:0]   rsv_dec;
   logic [NREG-1:0]   wr_dec;

   // Effective enables: with a hardwired zero register, address 0 is never
   // written or reserved, so it stays 0 and never becomes busy.
   logic we3_eff;
   logic we4_eff;
   logic rsv_eff;

   assign we3_eff = we3 && !((ZERO_REG != 0) && (wa3 == '0));
   assign we4_eff = we4 && !((ZERO_REG != 0) && (wa4 == '0));
   assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Reservation beats a completing write to the same register: a new
   // producer is in flight even though the older result just landed.
   always_comb begin
      rsv_dec   = '0;
      wr_dec    = '0;
      if (rsv_eff) rsv_dec = NREG'(1) << rsv_addr;
      if (we3_eff) wr_dec  = wr_dec | (NREG'(1) << wa3);
      if (we4_eff) wr_dec  = wr_dec | (NREG'(1) << wa4);
      busy_next = rsv_dec | (busy & ~wr_dec);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (we3_eff) regs[wa3] <= wd3;
         // Later assignment wins, so port 4 overrides port 3 on a collision.
         if (we4_eff) regs[wa4] <= wd4;
         busy <= busy_next;
      end
   end

   logic zero1;
   logic zero2;
   logic hit1;
   logic hit2;

   assign zero1 = (ZERO_REG != 0) && (ra1 == '0);
   assign zero2 = (ZERO_REG != 0) && (ra2 == '0);
   assign hit1  = (we3 && wa3 == ra1) || (we4 && wa4 == ra1);
   assign hit2  = (we3 && wa3 == ra2) || (we4 && wa4 == ra2);

   assign rd1 = zero1                  ? '0  :
                (we4 && wa4 == ra1)    ? wd4 :
                (we3 && wa3 == ra1)    ? wd3 : regs[ra1];
   assign rd2 = zero2                  ? '0  :
                (we4 && wa4 == ra2)    ? wd4 :
                (we3 && wa3 == ra2)    ? wd3 : regs[ra2];

   // A write completing this cycle satisfies the consumer via the bypass.
   assign busy1 = !zero1 && busy[ra1] && !hit1;
   assign busy2 = !zero2 && busy[ra2] && !hit2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra1, ra2, wa3, wa4, rsv_addr;
   logic [31:0] rd1, rd2, wd3, wd4;
   logic        busy1, busy2, we3, we4, rsv_en;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   // Reference state: contents and busy flags of all 32 registers.
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .we4(we4), .wa4(wa4), .wd4(wd4),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      if (ra == 0)                return 32'h0;
      if (we4 && wa4 == ra)       return wd4;
      if (we3 && wa3 == ra)       return wd3;
      return m_regs[ra];
   endfunction

   function automatic bit exp_busy(input logic [4:0] ra);
      if (ra == 0) return 1'b0;
      if ((we3 && wa3 == ra) || (we4 && wa4 == ra)) return 1'b0;
      return m_busy[ra];
   endfunction

   // Compare process: check outputs mid-cycle, then advance the model on the edge.
   initial begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      forever begin
         @(negedge clk);
         #3;
         if (chk_on) begin
            chk("rd1",   rd1,          exp_rd(ra1));
            chk("rd2",   rd2,          exp_rd(ra2));
            chk("busy1", {31'b0, busy1}, {31'b0, exp_busy(ra1)});
            chk("busy2", {31'b0, busy2}, {31'b0, exp_busy(ra2)});
         end
         @(posedge clk);
         if (reset) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
         end else begin
            if (we3 && wa3 != 0) begin m_regs[wa3] = wd3; m_busy[wa3] = 1'b0; end
            if (we4 && wa4 != 0) begin m_regs[wa4] = wd4; m_busy[wa4] = 1'b0; end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
         end
      end
   end

   task automatic idle();
      reset = 0; we3 = 0; we4 = 0; rsv_en = 0;
      wa3 = 0; wa4 = 0; wd3 = 0; wd4 = 0; rsv_addr = 0;
   endtask

   // Moves to the next cycle's drive point (negedge).
   task automatic next();
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      ra1 = 0; ra2 = 0;
      reset = 1;
      @(negedge clk); reset = 1;
      chk_on = 1'b1;

      // Post-reset state
      next(); ra1 = 5; ra2 = 31; #4;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
      chk("rst_busy1", {31'b0, busy1}, 32'h0);
      chk("rst_busy2", {31'b0, busy2}, 32'h0);

      // Write-through bypass, then array read
      next(); we3 = 1; wa3 = 5; wd3 = 32'h12345678; ra1 = 5; #4;
      chk("bypass_rd1", rd1, 32'h12345678);
      next(); ra1 = 5; #4;
      chk("array_rd1", rd1, 32'h12345678);

      // Port 4 wins on a same-address collision
      next(); we3 = 1; wa3 = 10; wd3 = 32'hDEADBEEF;
      we4 = 1; wa4 = 10; wd4 = 32'hCAFEF00D; ra1 = 10; #4;
      chk("p4win_bypass", rd1, 32'hCAFEF00D);
      next(); ra1 = 10; #4;
      chk("p4win_array", rd1, 32'hCAFEF00D);

      // Register 0 hardwired
      next(); we3 = 1; wa3 = 0; wd3 = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; ra1 = 0; #4;
      chk("r0_rd_same", rd1, 32'h0);
      chk("r0_busy_same", {31'b0, busy1}, 32'h0);
      next(); ra1 = 0; #4;
      chk("r0_rd_after", rd1, 32'h0);
      chk("r0_busy_after", {31'b0, busy1}, 32'h0);

      // Scoreboard sequence on register 7
      next(); rsv_en = 1; rsv_addr = 7; ra1 = 7; #4;
      chk("sb_n_busy", {31'b0, busy1}, 32'h0);
      next(); ra1 = 7; #4;
      chk("sb_n1_busy", {31'b0, busy1}, 32'h1);
      next(); ra1 = 7; #4;
      chk("sb_n2_busy", {31'b0, busy1}, 32'h1);
      next(); we4 = 1; wa4 = 7; wd4 = 32'h55; ra1 = 7; #4;
      chk("sb_n3_busy", {31'b0, busy1}, 32'h0);
      chk("sb_n3_rd", rd1, 32'h55);
      next(); ra1 = 7; #4;
      chk("sb_n4_busy", {31'b0, busy1}, 32'h0);
      chk("sb_n4_rd", rd1, 32'h55);
      next(); rsv_en = 1; rsv_addr = 7; we3 = 1; wa3 = 7; wd3 = 32'h99; ra1 = 7; #4;
      chk("sb_rsvwr_rd", rd1, 32'h99);
      next(); ra1 = 7; #4;
      chk("sb_rsvwr_rd_next", rd1, 32'h99);
      chk("sb_rsvwr_busy_next", {31'b0, busy1}, 32'h1);

      // Reset clears pending state, including same-cycle writes/reservations
      next(); rsv_en = 1; rsv_addr = 3; we3 = 1; wa3 = 4; wd3 = 32'h1;
      next(); reset = 1; ra1 = 3; ra2 = 4; rsv_en = 1; rsv_addr = 9;
      we4 = 1; wa4 = 9; wd4 = 32'hABCD; #4;
      chk("pre_rst_busy3", {31'b0, busy1}, 32'h1);
      chk("pre_rst_rd4", rd2, 32'h1);
      next(); ra1 = 3; ra2 = 4; #4;
      chk("mid_rst_rd1", rd1, 32'h0);
      chk("mid_rst_rd2", rd2, 32'h0);
      chk("mid_rst_busy1", {31'b0, busy1}, 32'h0);
      chk("mid_rst_busy2", {31'b0, busy2}, 32'h0);
      next(); ra1 = 9; ra2 = 9; #4;
      chk("mid_rst_rd9", rd1, 32'h0);
      chk("mid_rst_busy9", {31'b0, busy2}, 32'h0);

      // Random traffic; small address pool half the time to force collisions
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 63) == 0);
         we3      = $urandom_range(0, 1);
         we4      = $urandom_range(0, 1);
         rsv_en   = ($urandom_range(0, 9) < 3);
         wd3      = $urandom;
         wd4      = $urandom;
         wa3      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wa4      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rsv_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         ra1      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         ra2      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      end

      next();
      #4;
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
